cmp2_stream_monitor: RTL and testbench
======================================

Name: cmp2_stream_monitor

Overview:
Downstream stage for the 2-bit magnitude comparator. It accepts a stream of valid-qualified 2-bit A/B sample pairs and compares each pair. It registers the greater/equal/less flags and keeps saturating per-outcome event counters. An FSM raises a one-cycle pulse when A>B holds for RUN_LEN consecutive accepted samples; this feeds status/alarm logic.

Parameters:
CNT_W, 8, width of each event counter (valid range 2..16)
RUN_LEN, 3, consecutive A>B samples needed to fire run_detect (valid range 1..15)

Ports:
clk  input  1  single system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  sample qualifier; A/B are accepted on a rising clk edge when in_valid=1
A  input  2  operand A
B  input  2  operand B
clear  input  1  synchronous counter/run clear, one-cycle or level
A_great_B  output  1  registered A>B flag of last accepted sample
A_equal_B  output  1  registered A==B flag of last accepted sample
A_less_B  output  1  registered A<B flag of last accepted sample
out_valid  output  1  high for exactly one cycle after each accepted sample
gt_count  output  CNT_W  number of accepted samples with A>B
eq_count  output  CNT_W  number of accepted samples with A==B
lt_count  output  CNT_W  number of accepted samples with A<B
run_detect  output  1  one-cycle pulse, aligned with out_valid of the sample completing the run

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst. rst has priority over everything else.
- Reset values: all flags, out_valid, all counters and run_detect are 0. FSM is in IDLE with run_cnt=0.
- Latency: 1 cycle. A sample accepted at edge N drives its flags and out_valid=1 after edge N. Counter updates also become visible after edge N.
- Flag outputs: exactly one flag is high after the first accepted sample. Flags hold their value when in_valid=0. out_valid drops to 0 when no sample is accepted.
- Comparison: unsigned 2-bit magnitude.
- Counters: an accepted sample increments exactly one counter. Counters saturate at 2^CNT_W-1 and never wrap.
- clear: zeroes all three counters and returns the FSM to IDLE with run_cnt=0.
  - Flags and out_valid are not affected by clear.
  - If clear and in_valid are high together, the sample's flags and out_valid still register normally.
  - That sample is NOT counted and does NOT start a run.
- FSM states:
  - IDLE: run_cnt=0.
  - RUN: 1 <= run_cnt < RUN_LEN.
  - HIT: run satisfied.
- FSM transitions (only on accepted samples; cycles with in_valid=0 neither advance nor break a run):
  - IDLE + gt: if RUN_LEN=1, go to HIT and pulse run_detect; else go to RUN with run_cnt=1.
  - RUN + gt: run_cnt+1. If that equals RUN_LEN, go to HIT and pulse run_detect.
  - HIT + gt: stay in HIT, no further pulse.
  - Any state + eq or lt: go to IDLE, run_cnt=0, no pulse.
- run_detect is high for one cycle only, coincident with out_valid.
- Reset or clear mid-run discards partial run progress. A new run then needs RUN_LEN fresh gt samples.

Decomposition:
- Shared package:
  - FSM state encoding: IDLE=2'd0, RUN=2'd1, HIT=2'd2.
  - Comparison outcome encoding: CMP_LT, CMP_EQ, CMP_GT.
- One natural sub-module: cmp2_core. It is purely combinational: 2-bit A/B in, gt/eq/lt one-hot out.
- Flag registers, counters and the FSM live in cmp2_stream_monitor.

Test Plan:
- Reset: assert rst 2 cycles with in_valid=1, A=3, B=0 -> all outputs 0 during and one cycle after; counters remain 0.
- Single sample: A=2, B=1, in_valid for 1 cycle -> next cycle A_great_B=1, out_valid=1, gt_count=1; following cycle out_valid=0 and the flag holds.
- Exhaustive sweep: all 16 A/B pairs back-to-back -> gt_count=6, eq_count=4, lt_count=6. Each flag set matches A vs B with 1-cycle latency.
- Run detection (RUN_LEN=3), sample by sample:
  - Inputs: (3,0), gap 2 idle cycles, (2,1), (3,1), (3,2), (1,1), (2,0).
  - run_detect pulses once, with out_valid of (3,1); there is no pulse on (3,2).
  - After (1,1) the FSM is in IDLE; (2,0) leaves it in RUN, run_cnt=1.
- Saturation and clear (CNT_W=2):
  - 5 samples of A=1, B=1 -> eq_count=3.
  - Then clear together with A=3, B=0 valid -> counters all 0, A_great_B=1, out_valid=1.
  - Then 2 more (3,0) samples -> no run_detect (run needs 3 fresh samples).
- Reset mid-run: two gt samples, rst for 1 cycle, then three gt samples -> run_detect fires only on the third post-reset sample; gt_count=3.

Source files
------------

// File: rtl/cmp2_stream_monitor_pkg.sv
// ---------------------------------------------------------------------------
// cmp2_stream_monitor_pkg
// Shared types for the 2-bit comparator stream monitor:
//   run_state_t : run-detector FSM state (IDLE / RUN / HIT)
//   cmp_t       : encoded outcome of one A/B comparison
//   RUN_CNT_W   : width of the run-length counter (holds RUN_LEN up to 15)
//   encode_cmp  : folds the comparator's one-hot flags into a cmp_t
// ---------------------------------------------------------------------------
package cmp2_stream_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HIT  = 2'd2
    } run_state_t;

    typedef enum logic [1:0] {
        CMP_LT = 2'd0,
        CMP_EQ = 2'd1,
        CMP_GT = 2'd2
    } cmp_t;

    localparam int RUN_CNT_W = 4;

    // lt is implied when neither gt nor eq is set.
    function automatic cmp_t encode_cmp(input logic gt, input logic eq);
        if (gt)      return CMP_GT;
        else if (eq) return CMP_EQ;
        else         return CMP_LT;
    endfunction

endpackage

// File: rtl/cmp2_core.sv
// ---------------------------------------------------------------------------
// cmp2_core
// Purely combinational unsigned 2-bit magnitude comparator.
// Ports:
//   A, B : 2-bit operands
//   gt   : A > B
//   eq   : A == B
//   lt   : A < B      (exactly one of gt/eq/lt is high)
// ---------------------------------------------------------------------------
module cmp2_core (
    input  logic [1:0] A,
    input  logic [1:0] B,
    output logic       gt,
    output logic       eq,
    output logic       lt
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned; a missing default would infer a latch.
        gt = 1'b0;
        eq = 1'b0;
        lt = 1'b0;
        if (A > B)       gt = 1'b1;
        else if (A == B) eq = 1'b1;
        else             lt = 1'b1;
    end

endmodule

// File: rtl/cmp2_stream_monitor.sv
// ---------------------------------------------------------------------------
// cmp2_stream_monitor
// Accepts valid-qualified 2-bit A/B pairs, registers the comparison flags,
// keeps saturating per-outcome counters and pulses run_detect when A>B holds
// for RUN_LEN consecutive accepted samples.
// Parameters:
//   CNT_W   : event counter width (2..16)
//   RUN_LEN : consecutive A>B samples that complete a run (1..15)
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid, A, B       : sample qualifier and operands
//   clear                : zero counters and abandon any partial run
//   A_great_B/A_equal_B/A_less_B : flags of the last accepted sample
//   out_valid            : one cycle after each accepted sample
//   gt_count/eq_count/lt_count   : saturating outcome counters
//   run_detect           : one-cycle pulse with out_valid of the run's last sample
// ---------------------------------------------------------------------------
module cmp2_stream_monitor
    import cmp2_stream_monitor_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int RUN_LEN = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [1:0]       A,
    input  logic [1:0]       B,
    input  logic             clear,
    output logic             A_great_B,
    output logic             A_equal_B,
    output logic             A_less_B,
    output logic             out_valid,
    output logic [CNT_W-1:0] gt_count,
    output logic [CNT_W-1:0] eq_count,
    output logic [CNT_W-1:0] lt_count,
    output logic             run_detect
);

    localparam logic [CNT_W-1:0]     CNT_MAX    = '1;
    localparam logic [CNT_W-1:0]     CNT_ONE    = CNT_W'(1);
    localparam logic [RUN_CNT_W-1:0] RUN_TARGET = RUN_CNT_W'(RUN_LEN);
    localparam logic [RUN_CNT_W-1:0] RUN_ONE    = RUN_CNT_W'(1);

    logic                 cmp_gt;
    logic                 cmp_eq;
    logic                 cmp_lt;
    cmp_t                 outcome;
    run_state_t           state;
    logic [RUN_CNT_W-1:0] run_cnt;

    cmp2_core u_core (
        .A  (A),
        .B  (B),
        .gt (cmp_gt),
        .eq (cmp_eq),
        .lt (cmp_lt)
    );

    assign outcome = encode_cmp(cmp_gt, cmp_eq);

    // NOTE: all state (flags, counters, FSM) is reset here, inside the
    // clocked block, so reset is synchronous and overrides clear/in_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            A_great_B  <= 1'b0;
            A_equal_B  <= 1'b0;
            A_less_B   <= 1'b0;
            out_valid  <= 1'b0;
            run_detect <= 1'b0;
            gt_count   <= '0;
            eq_count   <= '0;
            lt_count   <= '0;
            state      <= IDLE;
            run_cnt    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            out_valid  <= in_valid;
            run_detect <= 1'b0;

            // Flags register on every accepted sample, even alongside clear.
            if (in_valid) begin
                A_great_B <= cmp_gt;
                A_equal_B <= cmp_eq;
                A_less_B  <= cmp_lt;
            end

            if (clear) begin
                // A sample arriving with clear is deliberately not counted
                // and cannot start a run.
                gt_count <= '0;
                eq_count <= '0;
                lt_count <= '0;
                state    <= IDLE;
                run_cnt  <= '0;
            end else if (in_valid) begin
                case (outcome)
                    CMP_GT:  if (gt_count != CNT_MAX) gt_count <= gt_count + CNT_ONE;
                    CMP_EQ:  if (eq_count != CNT_MAX) eq_count <= eq_count + CNT_ONE;
                    default: if (lt_count != CNT_MAX) lt_count <= lt_count + CNT_ONE;
                endcase

                if (outcome == CMP_GT) begin
                    case (state)
                        IDLE: begin
                            if (RUN_TARGET == RUN_ONE) begin
                                state      <= HIT;
                                run_cnt    <= RUN_ONE;
                                run_detect <= 1'b1;
                            end else begin
                                state   <= RUN;
                                run_cnt <= RUN_ONE;
                            end
                        end
                        RUN: begin
                            run_cnt <= run_cnt + RUN_ONE;
                            if (run_cnt + RUN_ONE == RUN_TARGET) begin
                                state      <= HIT;
                                run_detect <= 1'b1;
                            end
                        end
                        HIT: begin
                            // Run already reported; hold until broken.
                        end
                        default: begin
                            state   <= IDLE;
                            run_cnt <= '0;
                        end
                    endcase
                end else begin
                    state   <= IDLE;
                    run_cnt <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cmp2_stream_monitor.sv
// ---------------------------------------------------------------------------
// tb_cmp2_stream_monitor
// Two instances share the input stream: CNT_W=8 and CNT_W=2 (saturation),
// both with RUN_LEN=3. A reference model tracks raw outcome counts and the
// current streak of A>B samples; expected responses are queued per accepted
// sample and popped by an independent monitor on the falling edge.
// ---------------------------------------------------------------------------
module tb_cmp2_stream_monitor;

    localparam int RUN_LEN = 3;
    localparam int MAX8    = 255;
    localparam int MAX2    = 3;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [1:0] a;
    logic [1:0] b;
    logic       clear;

    logic       gt8, eq8, lt8, ov8, run8;
    logic [7:0] gtc8, eqc8, ltc8;
    logic       gt2, eq2, lt2, ov2, run2;
    logic [1:0] gtc2, eqc2, ltc2;

    cmp2_stream_monitor #(.CNT_W(8), .RUN_LEN(RUN_LEN)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .A(a), .B(b), .clear(clear),
        .A_great_B(gt8), .A_equal_B(eq8), .A_less_B(lt8), .out_valid(ov8),
        .gt_count(gtc8), .eq_count(eqc8), .lt_count(ltc8), .run_detect(run8)
    );

    cmp2_stream_monitor #(.CNT_W(2), .RUN_LEN(RUN_LEN)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .A(a), .B(b), .clear(clear),
        .A_great_B(gt2), .A_equal_B(eq2), .A_less_B(lt2), .out_valid(ov2),
        .gt_count(gtc2), .eq_count(eqc2), .lt_count(ltc2), .run_detect(run2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit gt;
        bit eq;
        bit lt;
        bit run;
        int gtc;
        int eqc;
        int ltc;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    // Reference model state: raw counts and current A>B streak length.
    int m_gt = 0;
    int m_eq = 0;
    int m_lt = 0;
    int m_streak = 0;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic void model_reset();
        m_gt = 0; m_eq = 0; m_lt = 0; m_streak = 0;
        exp_q.delete();
    endfunction

    function automatic void model_step(input int av, input int bv, input bit v, input bit clr);
        exp_t e;
        if (clr) begin
            m_gt = 0; m_eq = 0; m_lt = 0; m_streak = 0;
        end
        if (v) begin
            e.gt  = (av > bv);
            e.eq  = (av == bv);
            e.lt  = (av < bv);
            e.run = 1'b0;
            if (!clr) begin
                if (av > bv) begin
                    m_gt++;
                    m_streak++;
                    e.run = (m_streak == RUN_LEN);
                end else begin
                    if (av == bv) m_eq++;
                    else          m_lt++;
                    m_streak = 0;
                end
            end
            e.gtc = m_gt;
            e.eqc = m_eq;
            e.ltc = m_lt;
            exp_q.push_back(e);
        end
    endfunction

    task automatic step(input int av, input int bv, input bit v, input bit clr);
        a        = 2'(av);
        b        = 2'(bv);
        in_valid = v;
        clear    = clr;
        @(posedge clk);
        model_step(av, bv, v, clr);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input int n);
        rst      = 1'b1;
        in_valid = 1'b0;
        clear    = 1'b0;
        repeat (n) @(posedge clk);
        model_reset();
        #1;
        rst = 1'b0;
    endtask

    // Monitor: pops one expectation per out_valid, else no pulse allowed.
    always @(negedge clk) begin
        if (ov8) begin
            if (exp_q.size() == 0) begin
                check("spurious_out_valid", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("flags8",   {gt8, eq8, lt8}, {e.gt, e.eq, e.lt});
                check("flags2",   {gt2, eq2, lt2}, {e.gt, e.eq, e.lt});
                check("out_valid2", ov2, 1);
                check("run8",     run8, e.run);
                check("run2",     run2, e.run);
                check("gt_count8", gtc8, sat(e.gtc, MAX8));
                check("eq_count8", eqc8, sat(e.eqc, MAX8));
                check("lt_count8", ltc8, sat(e.ltc, MAX8));
                check("gt_count2", gtc2, sat(e.gtc, MAX2));
                check("eq_count2", eqc2, sat(e.eqc, MAX2));
                check("lt_count2", ltc2, sat(e.ltc, MAX2));
            end
        end else begin
            check("idle_outputs", {ov2, run8, run2}, 0);
        end
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b1;
        a        = 2'd3;
        b        = 2'd0;
        clear    = 1'b0;

        // Reset held two cycles with a valid gt sample on the inputs.
        repeat (2) begin
            @(negedge clk);
            check("reset_hold", {gt8, eq8, lt8, ov8, run8, gtc8, eqc8, ltc8}, 0);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("reset_after", {gt8, eq8, lt8, ov8, run8, gtc8, eqc8, ltc8}, 0);
        check("reset_after2", {gt2, eq2, lt2, gtc2, eqc2, ltc2}, 0);

        // Single sample, then flag must hold with out_valid low.
        step(2, 1, 1'b1, 1'b0);
        idle(1);
        @(negedge clk);
        check("single_ov_drop", ov8, 0);
        check("single_flag_hold", {gt8, eq8, lt8}, 3'b100);

        // Exhaustive sweep of all 16 pairs.
        do_reset(1);
        for (int i = 0; i < 16; i++) step(i / 4, i % 4, 1'b1, 1'b0);
        idle(1);
        @(negedge clk);
        check("sweep_gt8", gtc8, 6);
        check("sweep_eq8", eqc8, 4);
        check("sweep_lt8", ltc8, 6);
        check("sweep_sat2", {gtc2, eqc2, ltc2}, 6'b111111);

        // Run detection with idle gap inside the run.
        do_reset(1);
        step(3, 0, 1'b1, 1'b0);
        idle(2);
        step(2, 1, 1'b1, 1'b0);
        step(3, 1, 1'b1, 1'b0);
        step(3, 2, 1'b1, 1'b0);
        step(1, 1, 1'b1, 1'b0);
        step(2, 0, 1'b1, 1'b0);
        step(3, 0, 1'b1, 1'b0);
        step(2, 1, 1'b1, 1'b0);
        idle(1);

        // Saturation, then clear coincident with a sample.
        do_reset(1);
        for (int i = 0; i < 5; i++) step(1, 1, 1'b1, 1'b0);
        step(3, 0, 1'b1, 1'b1);
        step(3, 0, 1'b1, 1'b0);
        step(3, 0, 1'b1, 1'b0);
        idle(1);
        // Clear without a sample still zeroes the counters.
        step(0, 0, 1'b0, 1'b1);
        step(2, 2, 1'b1, 1'b0);
        idle(1);

        // Reset mid-run discards progress.
        step(3, 0, 1'b1, 1'b0);
        step(3, 0, 1'b1, 1'b0);
        do_reset(1);
        for (int i = 0; i < 3; i++) step(2, 0, 1'b1, 1'b0);
        idle(1);
        @(negedge clk);
        check("midrun_gt_count", gtc8, 3);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 2) begin
                do_reset(1);
            end else begin
                step($urandom_range(0, 3), $urandom_range(0, 3),
                     r < 80, ($urandom_range(0, 19) == 0));
            end
        end

        idle(3);
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
